// File: rtl/a2d_arb_pkg.sv
// Shared types and default widths for the A2D converter arbiter.
package a2d_arb_pkg;
    localparam int DEF_CHNL_W = 3;
    localparam int DEF_DATA_W = 12;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    // 0 = IR sensor / PI sequencer, 1 = battery/aux monitor
    typedef logic owner_t;
endpackage

// File: rtl/a2d_conv_arbiter_if.sv
// Requester + A2D bus for the arbiter; slave = arbiter side, master = requesters/converter side.
interface a2d_conv_arbiter_if
    import a2d_arb_pkg::*;
#(
    parameter int CHNL_W = DEF_CHNL_W,
    parameter int DATA_W = DEF_DATA_W
) ();
    logic              req0_vld,  req1_vld;
    logic [CHNL_W-1:0] req0_chnnl, req1_chnnl;
    logic              req0_lock, req1_lock;
    logic              req0_gnt,  req1_gnt;
    logic              req0_done, req1_done;
    logic              strt_cnv;
    logic [CHNL_W-1:0] a2d_chnnl;
    logic              cnv_cmplt;
    logic [DATA_W-1:0] a2d_res;
    logic [DATA_W-1:0] res;
    logic              busy;
    logic              timeout_err;
    logic              clr_err;

    modport slave (
        input  req0_vld, req0_chnnl, req0_lock, req1_vld, req1_chnnl, req1_lock,
        input  cnv_cmplt, a2d_res, clr_err,
        output req0_gnt, req0_done, req1_gnt, req1_done,
        output strt_cnv, a2d_chnnl, res, busy, timeout_err
    );

    modport master (
        output req0_vld, req0_chnnl, req0_lock, req1_vld, req1_chnnl, req1_lock,
        output cnv_cmplt, a2d_res, clr_err,
        input  req0_gnt, req0_done, req1_gnt, req1_done,
        input  strt_cnv, a2d_chnnl, res, busy, timeout_err
    );
endinterface

// File: rtl/a2d_timeout_timer.sv
// Saturating WAIT-state timer; expire is high while the count sits at LIMIT-1.
module a2d_timeout_timer #(
    parameter int LIMIT = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expire
);
    localparam int W = $clog2(LIMIT);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (en && cnt != '1)
            cnt <= cnt + W'(1);
    end

    assign expire = (cnt == LAST);
endmodule

// File: rtl/a2d_conv_arbiter.sv
// Round-robin arbiter sharing one A2D converter between two requesters, with hung-converter timeout.
// Optional A2D_ARB_LOCK_EN: owner's lock in DONE keeps the grant for its next request.
module a2d_conv_arbiter
    import a2d_arb_pkg::*;
#(
    parameter int CHNL_W      = DEF_CHNL_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic             clk,
    input  logic             rst,
    a2d_conv_arbiter_if.slave bus
);
    state_t            state;
    owner_t            owner, rr_ptr, pick;
    logic              go;
    logic [1:0]        gnt, done;
    logic              strt_cnv, timeout_err, tmr_expire;
    logic [CHNL_W-1:0] a2d_chnnl;
    logic [DATA_W-1:0] res;

`ifdef A2D_ARB_LOCK_EN
    logic lock_owner, owner_lock;
`else
    logic unused_lock;
    assign unused_lock = bus.req0_lock ^ bus.req1_lock;
`endif

    always_comb begin
        pick = rr_ptr ? bus.req1_vld : !bus.req0_vld;
        go   = bus.req0_vld | bus.req1_vld;
`ifdef A2D_ARB_LOCK_EN
        owner_lock = owner ? bus.req1_lock : bus.req0_lock;
        if (lock_owner && owner_lock) begin
            pick = owner;
            go   = owner ? bus.req1_vld : bus.req0_vld;
        end
`endif
    end

    a2d_timeout_timer #(.LIMIT(TIMEOUT_CYC)) u_tmr (
        .clk    (clk),
        .rst    (rst),
        .clear  (state == ISSUE),
        .en     (state == WAIT),
        .expire (tmr_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= 1'b0;
            rr_ptr      <= 1'b0;
            gnt         <= '0;
            done        <= '0;
            strt_cnv    <= 1'b0;
            timeout_err <= 1'b0;
            a2d_chnnl   <= '0;
            res         <= '0;
`ifdef A2D_ARB_LOCK_EN
            lock_owner  <= 1'b0;
`endif
        end else begin
            strt_cnv <= 1'b0;
            done     <= '0;
            // a timeout set later in this block overrides a same-cycle clear
            if (bus.clr_err)
                timeout_err <= 1'b0;
            case (state)
                IDLE: begin
`ifdef A2D_ARB_LOCK_EN
                    if (lock_owner && !owner_lock)
                        lock_owner <= 1'b0;
`endif
                    if (go) begin
                        owner     <= pick;
                        a2d_chnnl <= pick ? bus.req1_chnnl : bus.req0_chnnl;
                        gnt       <= pick ? 2'b10 : 2'b01;
                        strt_cnv  <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (bus.cnv_cmplt) begin
                        res   <= bus.a2d_res;
                        done  <= owner ? 2'b10 : 2'b01;
                        state <= DONE;
                    end else if (tmr_expire) begin
                        res         <= '0;
                        timeout_err <= 1'b1;
                        done        <= owner ? 2'b10 : 2'b01;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    gnt   <= '0;
                    state <= IDLE;
`ifdef A2D_ARB_LOCK_EN
                    if (owner_lock)
                        lock_owner <= 1'b1;
                    else
                        rr_ptr <= ~owner;
`else
                    rr_ptr <= ~owner;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req0_gnt    = gnt[0];
    assign bus.req1_gnt    = gnt[1];
    assign bus.req0_done   = done[0];
    assign bus.req1_done   = done[1];
    assign bus.strt_cnv    = strt_cnv;
    assign bus.a2d_chnnl   = a2d_chnnl;
    assign bus.res         = res;
    assign bus.busy        = (state != IDLE);
    assign bus.timeout_err = timeout_err;
endmodule
